pi_multi_ctrl: RTL and testbench

Parametrised, time-multiplexed discrete PI controller serving NCH voltage loops from one shared multiplier. On each start pulse it samples all channels, runs PI with conditional-integration anti-windup per channel in sequence, and emits per-channel duty codes. It replaces the fixed two-controller plus done-latch plus feedback-register arrangement; integrator and output state are held internally.

---
 rtl/pi_multi_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_pi_multi_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pi_multi_ctrl.sv
// Time-multiplexed PI controller: NCH voltage loops share one multiplier.
// Each channel runs ERR -> MI -> MP -> WB with conditional-integration anti-windup.
module pi_multi_ctrl #(
   parameter int NCH = 2,
   parameter int IW  = 16,
   parameter int GW  = 18,
   parameter int GF  = 14,
   parameter int AW  = 22,
   parameter int OW  = 7
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start_port,
   input  logic [NCH-1:0]    en_mask,
   input  logic [NCH*IW-1:0] vref_flat,
   input  logic [NCH*IW-1:0] vmeas_flat,
   input  logic [NCH*GW-1:0] kp_flat,
   input  logic [NCH*GW-1:0] ki_flat,
   output logic              busy,
   output logic              done_port,
   output logic [NCH*OW-1:0] duty_flat,
   output logic [NCH*AW-1:0] u_flat,
   output logic [NCH-1:0]    sat_flags
);
   localparam int EW  = IW + 1;
   localparam int PW  = EW + GW;
   localparam int SW  = PW + 1;
   localparam int IPW = AW - GF;
   localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int DMAX = (2 ** OW) - 1;
   localparam logic [KW-1:0] K_LAST = KW'(NCH - 1);
   localparam logic signed [AW-1:0] U_MAX = {1'b0, {(AW-1){1'b1}}};
   localparam logic signed [AW-1:0] U_MIN = {1'b1, {(AW-1){1'b0}}};
   localparam logic signed [SW-1:0] SUM_MAX = {{(SW-AW+1){1'b0}}, {(AW-1){1'b1}}};
   localparam logic signed [SW-1:0] SUM_MIN = {{(SW-AW+1){1'b1}}, {(AW-1){1'b0}}};

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ERR  = 3'd1;
   localparam logic [2:0] S_MI   = 3'd2;
   localparam logic [2:0] S_MP   = 3'd3;
   localparam logic [2:0] S_WB   = 3'd4;
   localparam logic [2:0] S_DONE = 3'd5;

   function automatic logic signed [AW-1:0] sat_aw(input logic signed [SW-1:0] v);
      if (v > SUM_MAX)      sat_aw = U_MAX;
      else if (v < SUM_MIN) sat_aw = U_MIN;
      else                  sat_aw = v[AW-1:0];
   endfunction

   function automatic logic ip_over(input logic signed [IPW-1:0] ip);
      ip_over = (int'(ip) > DMAX);
   endfunction

   function automatic logic [OW-1:0] clamp_duty(input logic signed [IPW-1:0] ip);
      int v;
      v = int'(ip);
      if (v < 0)         clamp_duty = '0;
      else if (v > DMAX) clamp_duty = '1;
      else               clamp_duty = OW'(v);
   endfunction

   logic [2:0]           state;
   logic [KW-1:0]        k;
   logic [NCH-1:0]       en_sh;
   logic [IW-1:0]        vref_sh  [NCH];
   logic [IW-1:0]        vmeas_sh [NCH];
   logic signed [GW-1:0] kp_sh    [NCH];
   logic signed [GW-1:0] ki_sh    [NCH];
   logic signed [AW-1:0] x_r      [NCH];
   logic signed [AW-1:0] u_r      [NCH];
   logic [OW-1:0]        duty_r   [NCH];
   logic [NCH-1:0]       sat_r;

   logic signed [EW-1:0] e_p0;
   logic signed [AW-1:0] xc_p1;
   logic signed [AW-1:0] uc_p2;
   logic [OW-1:0]        duty_p2;
   logic                 shi_p2, slo_p2;

   logic signed [EW-1:0]  e_next;
   logic signed [GW-1:0]  gain_sel;
   logic signed [AW-1:0]  addend;
   logic signed [PW-1:0]  prod;
   logic signed [SW-1:0]  sum;
   logic signed [AW-1:0]  sum_sat;
   logic signed [IPW-1:0] ip;
   logic                  hold_x;

   // The single shared multiplier: ki*e in MI, kp*e in MP.
   assign e_next   = $signed(EW'(vref_sh[k]) - EW'(vmeas_sh[k]));
   assign gain_sel = (state == S_MI) ? ki_sh[k] : kp_sh[k];
   assign addend   = (state == S_MI) ? x_r[k] : xc_p1;
   assign prod     = PW'(gain_sel) * PW'(e_p0);
   assign sum      = SW'(prod) + SW'(addend);
   assign sum_sat  = sat_aw(sum);
   assign ip       = sum_sat[AW-1:GF];
   assign hold_x   = (shi_p2 && !e_p0[EW-1] && (e_p0 != '0)) || (slo_p2 && e_p0[EW-1]);

   // Shadow capture and per-stage datapath registers
   always_ff @(posedge clock) begin
      if (state == S_IDLE && start_port) begin
         for (int i = 0; i < NCH; i++) begin
            vref_sh[i]  <= vref_flat[i*IW +: IW];
            vmeas_sh[i] <= vmeas_flat[i*IW +: IW];
            kp_sh[i]    <= kp_flat[i*GW +: GW];
            ki_sh[i]    <= ki_flat[i*GW +: GW];
         end
      end
      case (state)
         S_ERR: e_p0 <= e_next;
         S_MI:  xc_p1 <= sum_sat;
         S_MP: begin
            uc_p2   <= sum_sat;
            duty_p2 <= clamp_duty(ip);
            shi_p2  <= ip_over(ip) || (sum_sat == U_MAX);
            slo_p2  <= ip[IPW-1];
         end
         default: ;
      endcase
   end

   // Sequencer and committed per-channel state
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         k         <= '0;
         busy      <= 1'b0;
         done_port <= 1'b0;
         en_sh     <= '0;
         sat_r     <= '0;
         for (int i = 0; i < NCH; i++) begin
            x_r[i]    <= '0;
            u_r[i]    <= '0;
            duty_r[i] <= '0;
         end
      end else begin
         done_port <= 1'b0;
         case (state)
            S_IDLE: if (start_port) begin
               en_sh <= en_mask;
               busy  <= 1'b1;
               k     <= '0;
               state <= S_ERR;
            end
            S_ERR: state <= S_MI;
            S_MI:  state <= S_MP;
            S_MP:  state <= S_WB;
            S_WB: begin
               if (en_sh[k]) begin
                  u_r[k]    <= uc_p2;
                  duty_r[k] <= duty_p2;
                  sat_r[k]  <= shi_p2 | slo_p2;
                  if (!hold_x) x_r[k] <= xc_p1;
               end else begin
                  u_r[k]    <= '0;
                  duty_r[k] <= '0;
                  sat_r[k]  <= 1'b0;
                  x_r[k]    <= '0;
               end
               if (k == K_LAST) begin
                  state <= S_DONE;
               end else begin
                  k     <= k + KW'(1);
                  state <= S_ERR;
               end
            end
            S_DONE: begin
               done_port <= 1'b1;
               busy      <= 1'b0;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : g_pack
      assign duty_flat[g*OW +: OW] = duty_r[g];
      assign u_flat[g*AW +: AW]    = u_r[g];
   end
   assign sat_flags = sat_r;

endmodule

// File: tb/tb_pi_multi_ctrl.sv
// Randomized and directed bench for pi_multi_ctrl against an integer PI reference model.
module tb_pi_multi_ctrl;
   localparam int NCH = 2;
   localparam int IW  = 16;
   localparam int GW  = 18;
   localparam int GF  = 14;
   localparam int AW  = 22;
   localparam int OW  = 7;
   localparam longint UMAX = (64'sd1 <<< (AW-1)) - 1;
   localparam longint UMIN = -(64'sd1 <<< (AW-1));
   localparam longint DTOP = (64'sd1 <<< OW) - 1;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              start_port = 1'b0;
   logic [NCH-1:0]    en_mask = '0;
   logic [NCH*IW-1:0] vref_flat = '0;
   logic [NCH*IW-1:0] vmeas_flat = '0;
   logic [NCH*GW-1:0] kp_flat = '0;
   logic [NCH*GW-1:0] ki_flat = '0;
   logic              busy, done_port;
   logic [NCH*OW-1:0] duty_flat;
   logic [NCH*AW-1:0] u_flat;
   logic [NCH-1:0]    sat_flags;

   pi_multi_ctrl #(.NCH(NCH), .IW(IW), .GW(GW), .GF(GF), .AW(AW), .OW(OW)) dut (
      .clock(clock), .reset(reset), .start_port(start_port), .en_mask(en_mask),
      .vref_flat(vref_flat), .vmeas_flat(vmeas_flat), .kp_flat(kp_flat), .ki_flat(ki_flat),
      .busy(busy), .done_port(done_port), .duty_flat(duty_flat), .u_flat(u_flat),
      .sat_flags(sat_flags)
   );

   always #5 clock = ~clock;

   int nvec = 0;
   int nerr = 0;

   longint m_x [NCH];
   longint m_u [NCH];
   longint m_duty [NCH];
   bit     m_sat [NCH];
   int     t_vref [NCH];
   int     t_vmeas [NCH];
   longint t_kp [NCH];
   longint t_ki [NCH];

   function automatic longint sat_ref(input longint v);
      if (v > UMAX) return UMAX;
      if (v < UMIN) return UMIN;
      return v;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NCH; k++) begin
         m_x[k] = 0; m_u[k] = 0; m_duty[k] = 0; m_sat[k] = 0;
      end
   endtask

   // Controller law evaluated directly on integers
   task automatic model_run(input logic [NCH-1:0] en);
      longint e, xc, uc, ip;
      bit hi, lo;
      for (int k = 0; k < NCH; k++) begin
         if (!en[k]) begin
            m_x[k] = 0; m_u[k] = 0; m_duty[k] = 0; m_sat[k] = 0;
         end else begin
            e  = longint'(t_vref[k]) - longint'(t_vmeas[k]);
            xc = sat_ref(m_x[k] + t_ki[k] * e);
            uc = sat_ref(xc + t_kp[k] * e);
            ip = uc >>> GF;
            hi = (ip > DTOP) || (uc == UMAX);
            lo = (ip < 0);
            m_u[k]    = uc;
            m_duty[k] = lo ? 0 : ((ip > DTOP) ? DTOP : ip);
            m_sat[k]  = hi | lo;
            if (!((hi && e > 0) || (lo && e < 0))) m_x[k] = xc;
         end
      end
   endtask

   task automatic drive_inputs();
      for (int k = 0; k < NCH; k++) begin
         vref_flat[k*IW +: IW]  = IW'(t_vref[k]);
         vmeas_flat[k*IW +: IW] = IW'(t_vmeas[k]);
         kp_flat[k*GW +: GW]    = GW'(t_kp[k]);
         ki_flat[k*GW +: GW]    = GW'(t_ki[k]);
      end
   endtask

   task automatic scramble_inputs();
      for (int k = 0; k < NCH; k++) begin
         vref_flat[k*IW +: IW]  = IW'($urandom);
         vmeas_flat[k*IW +: IW] = IW'($urandom);
         kp_flat[k*GW +: GW]    = GW'($urandom);
         ki_flat[k*GW +: GW]    = GW'($urandom);
      end
   endtask

   task automatic set_ch(input int k, input int vr, input int vm, input longint kp, input longint ki);
      t_vref[k] = vr; t_vmeas[k] = vm; t_kp[k] = kp; t_ki[k] = ki;
   endtask

   task automatic do_reset();
      @(negedge clock); reset = 1'b0;
      @(negedge clock); reset = 1'b1;
      model_reset();
   endtask

   // One start; counts edges until done_port, optionally pulsing start at pulse_edge
   task automatic do_run(input logic [NCH-1:0] en, input int pulse_edge,
                         output int lat, output bit busy_ok);
      @(negedge clock);
      drive_inputs();
      en_mask = en;
      start_port = 1'b1;
      @(posedge clock); #1;
      start_port = 1'b0;
      scramble_inputs();
      en_mask = ~en;
      lat = 0;
      busy_ok = 1'b1;
      while (done_port !== 1'b1 && lat < 40) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         start_port = (lat == pulse_edge - 1);
         @(posedge clock); #1;
         lat++;
      end
      start_port = 1'b0;
      model_run(en);
   endtask

   task automatic check_run(input string name, input int lat, input bit busy_ok);
      nvec++;
      if (lat !== 4*NCH+1) begin
         nerr++; $display("FAIL %s latency: got %0d edges, expected %0d", name, lat, 4*NCH+1);
      end
      nvec++;
      if (busy_ok !== 1'b1 || busy !== 1'b0) begin
         nerr++; $display("FAIL %s busy window: busy_ok=%0d busy_at_done=%0d, expected 1/0", name, busy_ok, busy);
      end
      @(posedge clock); #1;
      nvec++;
      if (done_port !== 1'b0) begin
         nerr++; $display("FAIL %s done width: done still %0d one cycle later, expected 0", name, done_port);
      end
   endtask

   task automatic check_outputs(input string name);
      logic [AW-1:0] exp_u;
      logic [OW-1:0] exp_d;
      longint tu, td;
      for (int k = 0; k < NCH; k++) begin
         tu = m_u[k]; td = m_duty[k];
         exp_u = tu[AW-1:0];
         exp_d = td[OW-1:0];
         nvec++;
         if (u_flat[k*AW +: AW] !== exp_u) begin
            nerr++; $display("FAIL %s u%0d: got %0d expected %0d", name, k,
                             $signed(u_flat[k*AW +: AW]), $signed(exp_u));
         end
         nvec++;
         if (duty_flat[k*OW +: OW] !== exp_d) begin
            nerr++; $display("FAIL %s duty%0d: got %0d expected %0d", name, k, duty_flat[k*OW +: OW], exp_d);
         end
         nvec++;
         if (sat_flags[k] !== m_sat[k]) begin
            nerr++; $display("FAIL %s sat%0d: got %0d expected %0d", name, k, sat_flags[k], m_sat[k]);
         end
      end
   endtask

   task automatic check_const_u(input string name, input int k, input longint ue, input int de, input bit se);
      logic [AW-1:0] exp_u;
      exp_u = ue[AW-1:0];
      nvec++;
      if (u_flat[k*AW +: AW] !== exp_u || duty_flat[k*OW +: OW] !== OW'(de) || sat_flags[k] !== se) begin
         nerr++; $display("FAIL %s ch%0d: got u=%0d duty=%0d sat=%0d expected u=%0d duty=%0d sat=%0d",
                          name, k, $signed(u_flat[k*AW +: AW]), duty_flat[k*OW +: OW], sat_flags[k],
                          ue, de, se);
      end
   endtask

   task automatic check_all_zero(input string name);
      nvec++;
      if (busy !== 1'b0 || done_port !== 1'b0 || duty_flat !== '0 || u_flat !== '0 || sat_flags !== '0) begin
         nerr++; $display("FAIL %s: got busy=%0d done=%0d duty=%h u=%h sat=%b expected all zero",
                          name, busy, done_port, duty_flat, u_flat, sat_flags);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check_all_zero("reset_state");
      @(negedge clock); reset = 1'b1;
      model_reset();
   endtask

   task automatic test_basic();
      int lat; bit bok;
      set_ch(0, 10, 0, 16384, 8192);
      set_ch(1, 500, 500, 16384, 8192);
      do_run(2'b11, -1, lat, bok);
      check_run("basic1", lat, bok);
      check_outputs("basic1");
      check_const_u("basic1_const", 0, 245760, 15, 1'b0);
      do_run(2'b11, -1, lat, bok);
      check_run("basic2", lat, bok);
      check_outputs("basic2");
      check_const_u("basic2_const", 0, 327680, 20, 1'b0);
   endtask

   task automatic test_disable();
      int lat; bit bok;
      set_ch(1, 300, 200, 16384, 8192);
      do_run(2'b11, -1, lat, bok);
      check_run("dis_pre", lat, bok);
      check_outputs("dis_pre");
      do_run(2'b01, -1, lat, bok);
      check_run("disable", lat, bok);
      check_outputs("disable");
      check_const_u("disable_ch1", 1, 0, 0, 1'b0);
      // ch1 re-enabled with zero error must show its integrator was cleared
      set_ch(1, 200, 200, 16384, 8192);
      do_run(2'b11, -1, lat, bok);
      check_run("dis_post", lat, bok);
      check_outputs("dis_post");
      check_const_u("dis_post_ch1", 1, 0, 0, 1'b0);
   endtask

   task automatic test_neg_sat();
      int lat; bit bok;
      do_reset();
      set_ch(0, 0, 100, 16384, 8192);
      set_ch(1, 7, 7, 16384, 8192);
      do_run(2'b11, -1, lat, bok);
      check_run("negsat", lat, bok);
      check_outputs("negsat");
      check_const_u("negsat_const", 0, UMIN, 0, 1'b1);
      set_ch(0, 50, 50, 16384, 8192);
      do_run(2'b11, -1, lat, bok);
      check_outputs("negsat_hold");
      check_const_u("negsat_hold_const", 0, 0, 0, 1'b0);
   endtask

   task automatic test_pos_sat();
      int lat; bit bok;
      do_reset();
      set_ch(0, 0, 0, 16384, 8192);
      set_ch(1, 1000, 0, 16384, 8192);
      do_run(2'b11, -1, lat, bok);
      check_run("possat", lat, bok);
      check_outputs("possat");
      check_const_u("possat_const", 1, UMAX, 127, 1'b1);
      set_ch(1, 400, 400, 16384, 8192);
      do_run(2'b11, -1, lat, bok);
      check_outputs("possat_hold");
      check_const_u("possat_hold_const", 1, 0, 0, 1'b0);
   endtask

   task automatic test_busy_ignore();
      int lat, extra; bit bok;
      do_reset();
      set_ch(0, 10, 0, 16384, 8192);
      set_ch(1, 20, 5, 8000, 3000);
      do_run(2'b11, 3, lat, bok);
      check_run("busy_ignore", lat, bok);
      check_outputs("busy_ignore");
      extra = 0;
      repeat (15) begin
         @(posedge clock); #1;
         if (done_port === 1'b1 || busy === 1'b1) extra++;
      end
      nvec++;
      if (extra !== 0) begin
         nerr++; $display("FAIL busy_ignore extra_activity: got %0d cycles, expected 0", extra);
      end
   endtask

   task automatic test_reset_midrun();
      int lat, dones; bit bok;
      set_ch(0, 10, 0, 16384, 8192);
      set_ch(1, 30, 0, 16384, 8192);
      @(negedge clock);
      drive_inputs();
      en_mask = 2'b11;
      start_port = 1'b1;
      @(posedge clock); #1;
      start_port = 1'b0;
      repeat (5) @(posedge clock);
      #1 reset = 1'b0;
      #1;
      check_all_zero("reset_mid");
      dones = 0;
      repeat (3) begin
         @(posedge clock); #1;
         if (done_port === 1'b1) dones++;
      end
      @(negedge clock); reset = 1'b1;
      model_reset();
      repeat (6) begin
         @(posedge clock); #1;
         if (done_port === 1'b1) dones++;
      end
      nvec++;
      if (dones !== 0) begin
         nerr++; $display("FAIL reset_mid done_pulses: got %0d expected 0", dones);
      end
      do_run(2'b11, -1, lat, bok);
      check_run("after_reset", lat, bok);
      check_outputs("after_reset");
      check_const_u("after_reset_const", 0, 245760, 15, 1'b0);
   endtask

   task automatic test_random();
      int lat, tmp; bit bok;
      logic [NCH-1:0] en;
      logic [GW-1:0] r;
      do_reset();
      for (int n = 0; n < 25; n++) begin
         for (int k = 0; k < NCH; k++) begin
            if ($urandom_range(0, 3) == 0) begin
               t_vref[k]  = int'($urandom_range(0, 65535));
               t_vmeas[k] = int'($urandom_range(0, 65535));
            end else begin
               t_vref[k]  = int'($urandom_range(0, 300));
               t_vmeas[k] = int'($urandom_range(0, 300));
            end
            if ($urandom_range(0, 3) == 0) begin
               r = GW'($urandom); t_kp[k] = longint'($signed(r));
               r = GW'($urandom); t_ki[k] = longint'($signed(r));
            end else begin
               tmp = int'($urandom_range(0, 40000)) - 20000; t_kp[k] = tmp;
               tmp = int'($urandom_range(0, 40000)) - 20000; t_ki[k] = tmp;
            end
         end
         en = NCH'($urandom);
         if ($urandom_range(0, 2) != 0) en = '1;
         do_run(en, -1, lat, bok);
         check_run("random", lat, bok);
         check_outputs("random");
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic();
      test_disable();
      test_neg_sat();
      test_pos_sat();
      test_busy_ignore();
      test_reset_midrun();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
